// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, 3-sample majority vote, word held
// until the consumer acknowledges it; parity, framing and overrun flags.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 data,
  output logic [DATA_BITS-1:0] character,
  output logic                 dataReady,
  input  logic                 data_taken,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge on rxs
  // S_START  | qualifying the start bit (glitch rejection)
  // S_DATA   | shifting payload bits in, LSB first
  // S_PARITY | checking the parity bit
  // S_STOP   | sampling stop bit(s); last decision ends the frame
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_M1 = DIV_W'(DIV - 1);
  localparam int S_W = $clog2(OVERSAMPLE);
  localparam logic [S_W-1:0] S_LO   = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0] S_HI   = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam int BC_W = $clog2(DATA_BITS);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

  state_t               state_q;
  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  logic [DIV_W-1:0]     div_cnt_q;
  logic [S_W-1:0]       s_q;
  logic [BC_W-1:0]      bit_cnt_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_acc_q, frm_acc_q, busy_q;
  logic [DATA_BITS-1:0] char_q;
  logic                 rdy_q, perr_q, ferr_q, ovr_q;

  logic start_det, tick, decide, bit_d, par_calc, par_bad, frame_done, frm_err_d;

  assign start_det  = (state_q == S_IDLE) && rxs_prev_q && !rxs_q;
  assign tick       = (state_q != S_IDLE) && (div_cnt_q == '0);
  assign decide     = tick && (s_q == S_HI);
  assign bit_d      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
  assign par_calc   = (^shift_q) ^ bit_d;
  assign par_bad    = (PARITY == 1) ? ~par_calc : par_calc;
  assign frame_done = decide && (state_q == S_STOP) && (bit_cnt_q == STOP_LAST);
  assign frm_err_d  = frm_acc_q | ~bit_d;

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= data;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Tick divider: down-counter, parked at 0 while idle, reloaded on start detect.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      div_cnt_q <= start_det ? DIV_M1 : '0;
    end else if (div_cnt_q == '0) begin
      div_cnt_q <= DIV_M1;
    end else begin
      div_cnt_q <= div_cnt_q - 1'b1;
    end
  end

  // Receive FSM: sample counter, majority filter, shift register and frame flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      s_q       <= '0;
      bit_cnt_q <= '0;
      samp_q    <= 2'b11;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
      frm_acc_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (start_det) begin
        state_q   <= S_START;
        s_q       <= '0;
        bit_cnt_q <= '0;
        par_acc_q <= 1'b0;
        frm_acc_q <= 1'b0;
        busy_q    <= 1'b1;
      end
    end else begin
      if (tick) begin
        s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
        if (s_q == S_LO)  samp_q[0] <= rxs_q;
        if (s_q == S_MID) samp_q[1] <= rxs_q;
      end
      if (decide) begin
        if (state_q == S_START) begin
          if (bit_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_DATA;
          end
        end else if (state_q == S_DATA) begin
          shift_q <= {bit_d, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_q <= '0;
            state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end else if (state_q == S_PARITY) begin
          par_acc_q <= par_bad;
          state_q   <= S_STOP;
        end else begin
          if (!bit_d) frm_acc_q <= 1'b1;
          if (bit_cnt_q == STOP_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Consumer handshake: hold the word, flag overrun when a new one has nowhere to go.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      char_q <= '0;
      rdy_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (frame_done) begin
      if (!rdy_q || data_taken) begin
        char_q <= shift_q;
        perr_q <= par_acc_q;
        ferr_q <= frm_err_d;
        rdy_q  <= 1'b1;
        if (rdy_q) ovr_q <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (data_taken && rdy_q) begin
      rdy_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end
  end

  assign character   = char_q;
  assign dataReady   = rdy_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 8N2) at
// 3.2 MHz / 100 kbaud / x16, so one bit lasts 32 clocks.
module tb_uart_rx_param;

  localparam int BITC = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line [3];
  logic       take [3];
  logic [7:0] ch   [3];
  logic       rdy  [3];
  logic       pe   [3];
  logic       fe   [3];
  logic       ov   [3];
  logic       bz   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(3_200_000), .BAUD(100_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clock(clk), .resetn(rst_n), .data(line[0]), .character(ch[0]),
    .dataReady(rdy[0]), .data_taken(take[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .overrun_err(ov[0]), .busy(bz[0]));

  uart_rx_param #(.CLK_FREQ(3_200_000), .BAUD(100_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .clock(clk), .resetn(rst_n), .data(line[1]), .character(ch[1]),
    .dataReady(rdy[1]), .data_taken(take[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .overrun_err(ov[1]), .busy(bz[1]));

  uart_rx_param #(.CLK_FREQ(3_200_000), .BAUD(100_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .clock(clk), .resetn(rst_n), .data(line[2]), .character(ch[2]),
    .dataReady(rdy[2]), .data_taken(take[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .overrun_err(ov[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame image, LSB first: start(0), 8 data bits, then bit 9 (parity or stop), rest high.
  function automatic logic [15:0] frame(input logic [7:0] d, input logic b9);
    logic [15:0] v;
    v      = 16'hFFFF;
    v[0]   = 1'b0;
    v[8:1] = d;
    v[9]   = b9;
    return v;
  endfunction

  task automatic send_bits(input int d, input logic [15:0] v, input int n);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      line[d] = v[i];
      tick_n(BITC);
    end
  endtask

  task automatic ack(input int d);
    take[d] = 1'b1;
    tick_n(1);
    take[d] = 1'b0;
  endtask

  initial begin
    bit ok, saw_b, saw_r;
    logic [15:0] v;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1;
      take[i] = 1'b0;
    end
    tick_n(4);
    @(negedge clk);
    chk("reset_outputs", {ch[0], rdy[0], pe[0], fe[0], ov[0], bz[0]}, 0);
    rst_n = 1'b1;
    tick_n(4);

    // 1: 8N1 0xA5, ready within 34 clocks of the stop bit centre
    v = frame(8'hA5, 1'b1);
    send_bits(0, v, 9);
    line[0] = 1'b1;
    tick_n(BITC / 2);
    ok = 1'b0;
    for (int i = 0; i < 34 && !ok; i++) begin
      @(negedge clk);
      if (rdy[0]) ok = 1'b1;
    end
    chk("t1_ready_in_time", ok, 1);
    chk("t1_char", ch[0], 8'hA5);
    chk("t1_flags", {pe[0], fe[0], ov[0]}, 0);
    ack(0);
    @(negedge clk);
    chk("t1_ack_clears", rdy[0], 0);

    // 2: 8E1, 0x37 has five ones so even parity bit is 1
    send_bits(1, {5'h1F, 1'b1, frame(8'h37, 1'b1)} >> 0, 11);
    @(negedge clk);
    chk("t2_good_rdy", rdy[1], 1);
    chk("t2_good_char", ch[1], 8'h37);
    chk("t2_good_perr", pe[1], 0);
    ack(1);
    send_bits(1, frame(8'h37, 1'b0), 11);
    @(negedge clk);
    chk("t2_bad_rdy", rdy[1], 1);
    chk("t2_bad_char", ch[1], 8'h37);
    chk("t2_bad_perr", pe[1], 1);
    chk("t2_bad_ferr", fe[1], 0);
    ack(1);

    // 3: 8N2 with second stop bit low, then an immediate clean frame
    v = frame(8'hC3, 1'b1);
    v[10] = 1'b0;
    send_bits(2, v, 11);
    line[2] = 1'b1;
    @(negedge clk);
    chk("t3_rdy", rdy[2], 1);
    chk("t3_char", ch[2], 8'hC3);
    chk("t3_ferr", fe[2], 1);
    ack(2);
    send_bits(2, frame(8'h3C, 1'b1), 11);
    @(negedge clk);
    chk("t3_next_rdy", rdy[2], 1);
    chk("t3_next_char", ch[2], 8'h3C);
    chk("t3_next_ferr", fe[2], 0);
    ack(2);

    // 4: 4-clock low glitch on an idle line
    @(posedge clk);
    #1;
    line[0] = 1'b0;
    tick_n(4);
    line[0] = 1'b1;
    saw_b = 1'b0;
    saw_r = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bz[0])  saw_b = 1'b1;
      if (rdy[0]) saw_r = 1'b1;
    end
    chk("t4_busy_pulsed", saw_b, 1);
    chk("t4_no_ready", saw_r, 0);
    chk("t4_busy_end", bz[0], 0);

    // 5: overrun keeps the first word; ack clears ready and overrun
    send_bits(0, frame(8'h11, 1'b1), 10);
    send_bits(0, frame(8'h22, 1'b1), 10);
    @(negedge clk);
    chk("t5_char_kept", ch[0], 8'h11);
    chk("t5_rdy", rdy[0], 1);
    chk("t5_overrun", ov[0], 1);
    ack(0);
    @(negedge clk);
    chk("t5_ack_rdy", rdy[0], 0);
    chk("t5_ack_ovr", ov[0], 0);

    // 5b: completion and ack on the same edge -> new word, no overrun
    send_bits(0, frame(8'h66, 1'b1), 10);
    @(negedge clk);
    chk("t5b_first_char", ch[0], 8'h66);
    send_bits(0, frame(8'h44, 1'b1), 9);
    line[0] = 1'b1;
    tick_n(22);
    take[0] = 1'b1;
    tick_n(1);
    take[0] = 1'b0;
    tick_n(9);
    @(negedge clk);
    chk("t5b_char", ch[0], 8'h44);
    chk("t5b_rdy", rdy[0], 1);
    chk("t5b_ovr", ov[0], 0);
    ack(0);

    // 6: reset during data bit 3 with a word still held
    send_bits(0, frame(8'h33, 1'b1), 10);
    @(negedge clk);
    chk("t6_pre_rdy", rdy[0], 1);
    v = frame(8'h0F, 1'b1);
    send_bits(0, v, 4);
    line[0] = v[4];
    tick_n(10);
    @(negedge clk);
    chk("t6_busy_mid", bz[0], 1);
    rst_n = 1'b0;
    tick_n(2);
    @(negedge clk);
    chk("t6_reset_outputs", {ch[0], rdy[0], pe[0], fe[0], ov[0], bz[0]}, 0);
    line[0] = 1'b1;
    tick_n(3);
    rst_n = 1'b1;
    tick_n(4);
    send_bits(0, frame(8'h5A, 1'b1), 10);
    @(negedge clk);
    chk("t6_char", ch[0], 8'h5A);
    chk("t6_rdy", rdy[0], 1);
    chk("t6_flags", {pe[0], fe[0], ov[0]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
